// File: rtl/formant_pkg.sv
// Shared parameters and types for the formant DP column scheduler.
package formant_pkg;

    localparam int I        = 160;
    localparam int FORMANTS = 4;
    localparam int IDX_W    = $clog2(I);
    localparam int NUM_W    = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TB   = 2'd2,
        DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/formant_dp_sched_if.sv
// Frame control and engine handshake bundle of the column scheduler.
interface formant_dp_sched_if;
    import formant_pkg::*;

    logic              frame_start;
    logic [NUM_W-1:0]  num_i;
    logic              abort;
    logic              emin_start;
    logic [IDX_W-1:0]  emin_i;
    logic              emin_bank;
    logic              emin_done;
    logic              f_begin_iter;
    logic [IDX_W-1:0]  f_i;
    logic              f_bank;
    logic              f_iter_done;
    logic              tb_start;
    logic              tb_done;
    logic              frame_busy;
    logic              frame_done;
    logic              error;

    // Scheduler side.
    modport master (
        input  frame_start, num_i, abort, emin_done, f_iter_done, tb_done,
        output emin_start, emin_i, emin_bank, f_begin_iter, f_i, f_bank,
               tb_start, frame_busy, frame_done, error
    );

    // Frame control and engine side.
    modport slave (
        output frame_start, num_i, abort, emin_done, f_iter_done, tb_done,
        input  emin_start, emin_i, emin_bank, f_begin_iter, f_i, f_bank,
               tb_start, frame_busy, frame_done, error
    );

endinterface

// File: rtl/engine_tracker.sv
// Busy flag, completed-column counter and watchdog for one DP engine.
// busy_nx/cnt_nx already include this cycle's done pulse so the scheduler
// can issue the dependent start on the very next edge.
module engine_tracker
    import formant_pkg::*;
#(
    parameter int WATCHDOG = 4096
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             clr,
    input  logic             start,
    input  logic             done,
    output logic             busy_nx,
    output logic [NUM_W-1:0] cnt_nx,
    output logic             timeout,
    output logic             unexpected
);

    localparam int              WD_W    = $clog2(WATCHDOG + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WATCHDOG - 1);

    logic             busy_q, busy_d;
    logic [NUM_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             done_ok;

    // Done acceptance, down-counting watchdog with terminal count at zero.
    always_comb begin
        done_ok    = done && busy_q;
        unexpected = done && !busy_q;
        busy_nx    = busy_q && !done;
        cnt_nx     = cnt_q + NUM_W'(done_ok);
        timeout    = busy_q && !done && (wd_q == '0);
        busy_d     = busy_nx || start;
        cnt_d      = cnt_nx;
        wd_d       = wd_q - WD_W'(busy_q);
        if (start) begin
            wd_d = WD_LOAD;
        end
        if (clr) begin
            busy_d = start;
            cnt_d  = '0;
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            wd_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            wd_q   <= wd_d;
        end
    end

endmodule

// File: rtl/formant_dp_sched.sv
// Column scheduler: overlaps E-min and F engines over a double-buffered
// E-min store, then runs traceback and reports frame completion.
//
//   state | meaning
//   IDLE  | waiting for frame_start
//   RUN   | issuing E-min / F columns (empty frame passes through one cycle)
//   TB    | traceback running
//   DONE  | frame_done cycle
module formant_dp_sched
    import formant_pkg::*;
#(
    parameter int WATCHDOG = 4096
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    formant_dp_sched_if.master  bus
);

    sched_state_t     state_q, state_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic             emin_start_q, emin_start_d;
    logic [IDX_W-1:0] emin_i_q, emin_i_d;
    logic             emin_bank_q, emin_bank_d;
    logic             f_begin_q, f_begin_d;
    logic [IDX_W-1:0] f_i_q, f_i_d;
    logic             f_bank_q, f_bank_d;
    logic             tb_start_q, tb_start_d;
    logic             frame_busy_q, frame_busy_d;
    logic             frame_done_q, frame_done_d;
    logic             error_q, error_d;

    logic             trk_clr, e_go, f_go, t_go, wd_trip;
    logic             e_busy_nx, f_busy_nx, t_busy_nx;
    logic [NUM_W-1:0] e_cnt_nx, f_cnt_nx, t_cnt_unused, e_col_nx;
    logic             e_timeout, f_timeout, t_timeout;
    logic             e_unexp, f_unexp, t_unexp;

    engine_tracker #(.WATCHDOG(WATCHDOG)) u_emin (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .clr(trk_clr), .start(e_go),
        .done(bus.emin_done), .busy_nx(e_busy_nx), .cnt_nx(e_cnt_nx),
        .timeout(e_timeout), .unexpected(e_unexp)
    );

    engine_tracker #(.WATCHDOG(WATCHDOG)) u_f (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .clr(trk_clr), .start(f_go),
        .done(bus.f_iter_done), .busy_nx(f_busy_nx), .cnt_nx(f_cnt_nx),
        .timeout(f_timeout), .unexpected(f_unexp)
    );

    engine_tracker #(.WATCHDOG(WATCHDOG)) u_tb (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .clr(trk_clr), .start(t_go),
        .done(bus.tb_done), .busy_nx(t_busy_nx), .cnt_nx(t_cnt_unused),
        .timeout(t_timeout), .unexpected(t_unexp)
    );

    // Frame FSM and column start decisions from post-done tracker state.
    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        trk_clr  = 1'b0;
        e_go     = 1'b0;
        f_go     = 1'b0;
        t_go     = 1'b0;
        wd_trip  = e_timeout || f_timeout || t_timeout;
        error_d  = error_q || e_unexp || f_unexp || t_unexp || wd_trip;
        if (bus.abort || wd_trip) begin
            state_d = IDLE;
            trk_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.frame_start) begin
                        if (bus.num_i > NUM_W'(I)) begin
                            error_d = 1'b1;
                        end else begin
                            num_d   = bus.num_i;
                            trk_clr = 1'b1;
                            error_d = e_unexp || f_unexp || t_unexp;
                            state_d = RUN;
                            e_go    = (bus.num_i != '0);
                        end
                    end
                end
                RUN: begin
                    if (num_q == '0) begin
                        state_d = DONE;
                    end else if (f_cnt_nx == num_q) begin
                        state_d = TB;
                        t_go    = 1'b1;
                    end else begin
                        // E-min may lead F by one column: both banks in use.
                        e_go = !e_busy_nx && (e_cnt_nx < num_q)
                               && (f_cnt_nx + NUM_W'(1) >= e_cnt_nx);
                        f_go = !f_busy_nx && (f_cnt_nx < e_cnt_nx);
                    end
                end
                TB: begin
                    if (!t_busy_nx) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        e_col_nx     = trk_clr ? '0 : e_cnt_nx;
        emin_start_d = e_go;
        emin_i_d     = e_go ? e_col_nx[IDX_W-1:0] : emin_i_q;
        emin_bank_d  = e_go ? e_col_nx[0] : emin_bank_q;
        f_begin_d    = f_go;
        f_i_d        = f_go ? f_cnt_nx[IDX_W-1:0] : f_i_q;
        f_bank_d     = f_go ? f_cnt_nx[0] : f_bank_q;
        tb_start_d   = t_go;
        frame_busy_d = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    // Registered state and outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            num_q        <= '0;
            emin_start_q <= 1'b0;
            emin_i_q     <= '0;
            emin_bank_q  <= 1'b0;
            f_begin_q    <= 1'b0;
            f_i_q        <= '0;
            f_bank_q     <= 1'b0;
            tb_start_q   <= 1'b0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            emin_start_q <= emin_start_d;
            emin_i_q     <= emin_i_d;
            emin_bank_q  <= emin_bank_d;
            f_begin_q    <= f_begin_d;
            f_i_q        <= f_i_d;
            f_bank_q     <= f_bank_d;
            tb_start_q   <= tb_start_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
            error_q      <= error_d;
        end
    end

    assign bus.emin_start   = emin_start_q;
    assign bus.emin_i       = emin_i_q;
    assign bus.emin_bank    = emin_bank_q;
    assign bus.f_begin_iter = f_begin_q;
    assign bus.f_i          = f_i_q;
    assign bus.f_bank       = f_bank_q;
    assign bus.tb_start     = tb_start_q;
    assign bus.frame_busy   = frame_busy_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.error        = error_q;

endmodule

// File: tb/tb_formant_dp_sched.sv
// Bench for formant_dp_sched: engine responders with per-column latencies and
// a dataflow-recurrence model of when each column start must appear.
module tb_formant_dp_sched;
    import formant_pkg::*;

    localparam int WD = 16;
    localparam int NA = 256;

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    formant_dp_sched_if ifc();

    formant_dp_sched #(.WATCHDOG(WD)) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .bus(ifc)
    );

    int vectors = 0;
    int miscompares = 0;
    int now = 0;

    int e_n, f_n, tb_cnt, fd_cnt, tbs_obs, fd_obs, err_first;
    int e_obs[NA], e_col[NA], e_bnk[NA], f_obs[NA], f_col[NA], f_bnk[NA];
    int lat_e[NA], lat_f[NA], lat_t;
    int es[NA], ed[NA], fs[NA], fd[NA];
    int e_due, f_due, t_due;
    bit e_pend, f_pend, t_pend, f_mute, busy_seen, err_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return {8'd0, ifc.emin_start, ifc.emin_i, ifc.emin_bank, ifc.f_begin_iter,
                ifc.f_i, ifc.f_bank, ifc.tb_start, ifc.frame_busy, ifc.frame_done,
                ifc.error};
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One cycle: engine responders drive dones, outputs are recorded.
    task automatic tick();
        @(negedge clk_in);
        now++;
        ifc.frame_start = 1'b0;
        ifc.abort       = 1'b0;
        ifc.emin_done   = 1'b0;
        ifc.f_iter_done = 1'b0;
        ifc.tb_done     = 1'b0;
        if (!ifc.frame_busy) begin
            e_pend = 1'b0; f_pend = 1'b0; t_pend = 1'b0;
        end
        if (e_pend && now == e_due) begin ifc.emin_done = 1'b1;   e_pend = 1'b0; end
        if (f_pend && now == f_due) begin ifc.f_iter_done = 1'b1; f_pend = 1'b0; end
        if (t_pend && now == t_due) begin ifc.tb_done = 1'b1;     t_pend = 1'b0; end
        if (ifc.emin_start) begin
            e_due = now + 1;
            if (e_n < NA) begin
                e_obs[e_n] = now; e_col[e_n] = int'(ifc.emin_i); e_bnk[e_n] = int'(ifc.emin_bank);
                e_due = now + lat_e[e_n];
            end
            e_pend = 1'b1;
            e_n++;
        end
        if (ifc.f_begin_iter) begin
            f_due = now + 1;
            if (f_n < NA) begin
                f_obs[f_n] = now; f_col[f_n] = int'(ifc.f_i); f_bnk[f_n] = int'(ifc.f_bank);
                f_due = now + lat_f[f_n];
            end
            f_pend = !f_mute;
            f_n++;
        end
        if (ifc.tb_start) begin
            tbs_obs = now; t_due = now + lat_t; t_pend = 1'b1; tb_cnt++;
        end
        if (ifc.frame_done) begin
            fd_cnt++; fd_obs = now;
        end
        if (ifc.frame_busy) busy_seen = 1'b1;
        if (ifc.error && err_first < 0) begin
            err_first = now; err_busy = ifc.frame_busy;
        end
    endtask

    task automatic prep(input int lat_fix, input int lat_max);
        e_n = 0; f_n = 0; tb_cnt = 0; fd_cnt = 0; tbs_obs = -1; fd_obs = -1;
        err_first = -1; busy_seen = 1'b0;
        for (int c = 0; c < NA; c++) begin
            e_obs[c] = -1; f_obs[c] = -1;
            lat_e[c] = (lat_fix > 0) ? lat_fix : int'($urandom_range(lat_max, 1));
            lat_f[c] = (lat_fix > 0) ? lat_fix : int'($urandom_range(lat_max, 1));
        end
        lat_t = (lat_fix > 0) ? lat_fix : int'($urandom_range(lat_max, 1));
    endtask

    // Full frame run compared against the dependency recurrence.
    task automatic run_frame(input int num, input int lat_fix, input int lat_max);
        int a, exp_tbs, exp_fd;
        prep(lat_fix, lat_max);
        ifc.num_i = NUM_W'(num);
        ifc.frame_start = 1'b1;
        a = now;
        if (num == 0) begin
            exp_tbs = -1;
            exp_fd  = a + 2;
        end else begin
            for (int c = 0; c < num; c++) begin
                if (c == 0) es[c] = a + 1;
                else        es[c] = imax(ed[c-1], (c >= 2) ? fd[c-2] : 0) + 1;
                ed[c] = es[c] + lat_e[c];
                fs[c] = imax(ed[c], (c >= 1) ? fd[c-1] : 0) + 1;
                fd[c] = fs[c] + lat_f[c];
            end
            exp_tbs = fd[num-1] + 1;
            exp_fd  = exp_tbs + lat_t + 1;
        end
        for (int k = 0; k < 8000 && fd_cnt == 0; k++) tick();
        tick();
        chk($sformatf("n%0d_busy_fall", num), ifc.frame_busy, 0);
        tick();
        chk($sformatf("n%0d_e_count", num), e_n, num);
        chk($sformatf("n%0d_f_count", num), f_n, num);
        for (int c = 0; c < num; c++) begin
            chk($sformatf("n%0d_e_start[%0d]", num, c), e_obs[c], es[c]);
            chk($sformatf("n%0d_e_col[%0d]", num, c), e_col[c], c);
            chk($sformatf("n%0d_e_bank[%0d]", num, c), e_bnk[c], c % 2);
            chk($sformatf("n%0d_f_start[%0d]", num, c), f_obs[c], fs[c]);
            chk($sformatf("n%0d_f_col[%0d]", num, c), f_col[c], c);
            chk($sformatf("n%0d_f_bank[%0d]", num, c), f_bnk[c], c % 2);
        end
        chk($sformatf("n%0d_tb_start", num), tbs_obs, exp_tbs);
        chk($sformatf("n%0d_tb_count", num), tb_cnt, (num > 0) ? 1 : 0);
        chk($sformatf("n%0d_frame_done", num), fd_obs, exp_fd);
        chk($sformatf("n%0d_done_count", num), fd_cnt, 1);
        chk($sformatf("n%0d_error", num), ifc.error, 0);
    endtask

    initial begin
        ifc.frame_start = 1'b0; ifc.num_i = '0; ifc.abort = 1'b0;
        ifc.emin_done = 1'b0; ifc.f_iter_done = 1'b0; ifc.tb_done = 1'b0;
        f_mute = 1'b0;
        prep(1, 1);

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", outs_vec(), 0);
        rst_n_in = 1'b1;
        tick();
        chk("post_reset_outputs", outs_vec(), 0);

        // Directed frames: overlap pattern, empty frame, simultaneous dones
        run_frame(3, 5, 0);
        run_frame(0, 1, 0);
        run_frame(4, 5, 0);

        // Stray done while idle sets the sticky error; next frame clears it
        ifc.emin_done = 1'b1;
        tick();
        tick();
        chk("stray_done_error", ifc.error, 1);
        run_frame(2, 0, 6);

        // Oversized frame is refused
        prep(1, 1);
        ifc.num_i = NUM_W'(I + 1);
        ifc.frame_start = 1'b1;
        repeat (8) tick();
        chk("badnum_error", ifc.error, 1);
        chk("badnum_busy_seen", busy_seen, 0);
        chk("badnum_done", fd_cnt, 0);
        chk("badnum_starts", e_n, 0);

        // Watchdog on a silent F engine
        prep(3, 0);
        f_mute = 1'b1;
        ifc.num_i = NUM_W'(1);
        ifc.frame_start = 1'b1;
        tick();
        chk("wd_error_cleared", ifc.error, 0);
        err_first = -1;
        repeat (40) tick();
        chk("wd_f_started", f_n, 1);
        chk("wd_error_cycle", err_first, f_obs[0] + WD);
        chk("wd_busy_at_error", err_busy, 0);
        chk("wd_no_done", fd_cnt, 0);
        chk("wd_no_tb", tb_cnt, 0);
        chk("wd_error_sticky", ifc.error, 1);
        f_mute = 1'b0;

        // Randomized frames
        for (int r = 0; r < 6; r++) begin
            run_frame(int'($urandom_range(8, 1)), 0, 10);
        end

        // Abort mid-frame
        prep(0, 6);
        ifc.num_i = NUM_W'(5);
        ifc.frame_start = 1'b1;
        repeat (10) tick();
        ifc.abort = 1'b1;
        tick();
        chk("abort_busy", ifc.frame_busy, 0);
        repeat (20) tick();
        chk("abort_no_done", fd_cnt, 0);
        chk("abort_error", ifc.error, 0);

        // Reset mid-frame, then a clean restart from column 0
        prep(0, 6);
        ifc.num_i = NUM_W'(6);
        ifc.frame_start = 1'b1;
        repeat (12) tick();
        rst_n_in = 1'b0;
        #1;
        chk("midreset_outputs", outs_vec(), 0);
        tick();
        rst_n_in = 1'b1;
        tick();
        run_frame(3, 0, 6);

        // Largest legal frame
        run_frame(I, 0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
